wiring_step_driver: RTL and testbench

- Host-side controller for a generated Wiring netlist.
- Accepts one input-trigger vector per request over valid/ready.
- Fires the vector into the netlist as a one-cycle pulse, waits for the netlist to settle (wiring_running quiet), then captures the outputs.
- Returns the outputs, the settle cycle count and a timeout flag, then pulses logic_reset to clear per-step gate state.

---
 rtl/wiring_drv_pkg.sv | 16 +
 rtl/wiring_settle_detector.sv | 42 ++++
 rtl/wiring_step_driver.sv | 129 ++++++++++++
 tb/tb_wiring_step_driver.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wiring_drv_pkg.sv
// Shared types and defaults for the Wiring netlist step driver.
package wiring_drv_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    FIRE,
    WAIT,
    CAPTURE,
    RESP
  } state_e;

  localparam int QUIET_CYCLES_DEF   = 2;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/wiring_settle_detector.sv
// Tracks how long the netlist has been quiet and how long the step has been waiting.
// settled/timed_out look at the post-update counts so the FSM can leave WAIT on the deciding edge.
module wiring_settle_detector #(
  parameter int QUIET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             wire_running,
  output logic             settled,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] QUIET_C   = CNT_W'(QUIET_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] quiet_q, quiet_d, cyc_q, cyc_d;

  always_comb begin
    quiet_d = wire_running ? '0 : quiet_q + 1'b1;
    cyc_d   = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
  end

  assign settled   = enable && (quiet_d >= QUIET_C);
  assign timed_out = enable && (cyc_d >= TIMEOUT_C);
  assign cycles    = cyc_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      quiet_q <= '0;
      cyc_q   <= '0;
    end else if (enable) begin
      quiet_q <= quiet_d;
      cyc_q   <= cyc_d;
    end
  end

endmodule

// File: rtl/wiring_step_driver.sv
// Host-side step controller: pulse a trigger vector into the netlist, wait for it to go
// quiet (or time out), capture its outputs, return them, then clear per-step gate state.
module wiring_step_driver
  import wiring_drv_pkg::*;
#(
  parameter int INPUT_WIDTH    = 2,
  parameter int OUTPUT_WIDTH   = 1,
  parameter int QUIET_CYCLES   = QUIET_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INPUT_WIDTH-1:0]  req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUTPUT_WIDTH-1:0] rsp_data,
  output logic                    rsp_timeout,
  output logic [CNT_W-1:0]        rsp_cycles,
  output logic [INPUT_WIDTH-1:0]  wire_in,
  output logic                    wire_logic_reset,
  input  logic                    wire_running,
  input  logic [OUTPUT_WIDTH-1:0] wire_out,
  output logic                    busy
);

  state_e state_q, state_d;

  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [OUTPUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]        rsp_cycles_q, rsp_cycles_d;
  logic [INPUT_WIDTH-1:0]  wire_in_q, wire_in_d;
  logic                    wlr_q, wlr_d;
  logic                    busy_q, busy_d;
  logic                    to_flag_q, to_flag_d;

  logic                    accept, settled, timed_out;
  logic [CNT_W-1:0]        cycles;

  assign accept = (state_q == IDLE) && req_valid && req_ready_q;

  wiring_settle_detector #(
    .QUIET_CYCLES  (QUIET_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle (
    .clk         (clk),
    .reset       (reset),
    .clear       (accept),
    .enable      (state_q == WAIT),
    .wire_running(wire_running),
    .settled     (settled),
    .timed_out   (timed_out),
    .cycles      (cycles)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_cycles_q  <= '0;
      wire_in_q     <= '0;
      wlr_q         <= 1'b0;
      busy_q        <= 1'b1;
      to_flag_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_cycles_q  <= rsp_cycles_d;
      wire_in_q     <= wire_in_d;
      wlr_q         <= wlr_d;
      busy_q        <= busy_d;
      to_flag_q     <= to_flag_d;
    end
  end

  // CLEAR lingers until its logic_reset pulse has actually been driven, which also
  // covers the entry straight out of reset where the pulse register was held low.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (wlr_q) state_d = IDLE;
      IDLE:    if (accept) state_d = FIRE;
      FIRE:    state_d = WAIT;
      WAIT:    if (settled || timed_out) state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_valid_q && rsp_ready) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    req_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    wlr_d         = (state_d == CLEAR);
    rsp_valid_d   = (state_d == RESP);
    wire_in_d     = (state_d == FIRE) ? req_data : '0;
    to_flag_d     = to_flag_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_cycles_d  = rsp_cycles_q;
    if (state_q == WAIT) to_flag_d = timed_out && !settled;
    if (state_q == CAPTURE) begin
      rsp_data_d    = wire_out;
      rsp_timeout_d = to_flag_q;
      rsp_cycles_d  = cycles;
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_timeout      = rsp_timeout_q;
  assign rsp_cycles       = rsp_cycles_q;
  assign wire_in          = wire_in_q;
  assign wire_logic_reset = wlr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_wiring_step_driver.sv
// Directed bench for wiring_step_driver: a stub netlist replays running/out patterns
// relative to the FIRE pulse, or behaves as a latching 2-input AND.
module tb_wiring_step_driver;

  localparam int IW = 2;
  localparam int OW = 1;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [IW-1:0] req_data;
  logic          rsp_valid, rsp_ready;
  logic [OW-1:0] rsp_data;
  logic          rsp_timeout;
  logic [CW-1:0] rsp_cycles;
  logic [IW-1:0] wire_in;
  logic          wire_logic_reset;
  logic          wire_running;
  logic [OW-1:0] wire_out;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // stub netlist configuration
  logic [31:0] run_pat  = '0;
  logic [31:0] out_pat  = '0;
  int          run_len  = 0;
  logic        run_tail = 1'b0;
  logic        and_mode = 1'b0;
  int          idx      = 100;
  logic        stub_out;
  logic        and_q;

  wiring_step_driver #(
    .INPUT_WIDTH   (IW),
    .OUTPUT_WIDTH  (OW),
    .QUIET_CYCLES  (2),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_data        (req_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_timeout     (rsp_timeout),
    .rsp_cycles      (rsp_cycles),
    .wire_in         (wire_in),
    .wire_logic_reset(wire_logic_reset),
    .wire_running    (wire_running),
    .wire_out        (wire_out),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Pattern index 0 lines up with the first WAIT cycle after the FIRE pulse.
  always @(negedge clk) begin
    if (wire_in != '0) begin
      idx          = 0;
      wire_running = 1'b0;
      stub_out     = 1'b0;
    end else begin
      wire_running = (idx < run_len) ? run_pat[idx] : run_tail;
      stub_out     = (idx < 32) ? out_pat[idx] : 1'b0;
      if (idx < 1000) idx = idx + 1;
    end
  end

  always @(posedge clk) begin
    if (reset || wire_logic_reset) and_q <= 1'b0;
    else if (&wire_in) and_q <= 1'b1;
  end

  assign wire_out = and_mode ? and_q : stub_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [31:0] pat, input int len, input logic tail, input logic [31:0] opat);
    run_pat  = pat;
    run_len  = len;
    run_tail = tail;
    out_pat  = opat;
    @(negedge clk);
  endtask

  // Returns at the first WAIT cycle (two negedges after the accept edge).
  task automatic fire_req(input logic [IW-1:0] d);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_data  = d;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("fire_wire_in", 32'(wire_in), 32'(d));
    chk("fire_busy", 32'(busy), 32'd1);
    chk("fire_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("fire_one_cycle", 32'(wire_in), 32'd0);
  endtask

  task automatic wait_rsp(input int exp_lat);
    int n;
    n = 2;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic check_rsp(input logic [OW-1:0] d, input logic to, input int cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(d));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(to));
    chk("rsp_cycles", 32'(rsp_cycles), 32'(cyc));
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_wlr", 32'(wire_logic_reset), 32'd1);
    chk("done_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("done_wlr_off", 32'(wire_logic_reset), 32'd0);
    chk("done_ready", 32'(req_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // reset sequence
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_wlr", 32'(wire_logic_reset), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_wire_in", 32'(wire_in), 32'd0);
      chk("rst_rsp_fields", {15'd0, rsp_cycles, rsp_timeout, rsp_data}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rel1_wlr", 32'(wire_logic_reset), 32'd1);
    chk("rel1_req_ready", 32'(req_ready), 32'd0);
    chk("rel1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rel2_wlr", 32'(wire_logic_reset), 32'd0);
    chk("rel2_req_ready", 32'(req_ready), 32'd1);
    chk("rel2_busy", 32'(busy), 32'd0);

    // running high for 5 cycles after the pulse, out=1
    cfg(32'h1F, 5, 1'b0, 32'hFFFF_FFFF);
    fire_req(2'b11);
    wait_rsp(10);
    check_rsp(1'b1, 1'b0, 7);
    finish_rsp();

    // all-zero trigger, quiet netlist: minimum latency
    cfg(32'h0, 0, 1'b0, 32'h0);
    fire_req(2'b00);
    wait_rsp(5);
    check_rsp(1'b0, 1'b0, 2);
    finish_rsp();

    // stuck running: forced capture, out only high in the CAPTURE cycle
    cfg(32'h0, 0, 1'b1, 32'h0000_0100);
    fire_req(2'b01);
    wait_rsp(11);
    check_rsp(1'b1, 1'b1, 8);
    finish_rsp();

    // settle and timeout on the same edge: quiet wins
    cfg(32'h3F, 6, 1'b0, 32'h0);
    fire_req(2'b10);
    wait_rsp(11);
    check_rsp(1'b0, 1'b0, 8);
    finish_rsp();

    // glitchy settle 1,0,1,0,0
    cfg(32'h5, 5, 1'b0, 32'hFFFF_FFFF);
    fire_req(2'b11);
    wait_rsp(8);
    check_rsp(1'b1, 1'b0, 5);
    finish_rsp();

    // backpressure with a second request held pending
    cfg(32'h0, 0, 1'b0, 32'hFFFF_FFFF);
    rsp_ready = 1'b0;
    fire_req(2'b01);
    wait_rsp(5);
    req_valid = 1'b1;
    req_data  = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_fields", {13'd0, rsp_valid, req_ready, rsp_cycles, rsp_timeout, rsp_data},
          {13'd0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b1});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_hs_wlr", 32'(wire_logic_reset), 32'd1);
    chk("bp_hs_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_ready_again", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("bp_accept_2cyc", 32'(wire_in), 32'd2);
    req_valid = 1'b0;
    @(negedge clk);
    wait_rsp(5);
    check_rsp(1'b1, 1'b0, 2);
    finish_rsp();

    // AND netlist after a fresh reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("and_ready", 32'(req_ready), 32'd1);
    and_mode = 1'b1;
    cfg(32'h1, 1, 1'b0, 32'h0);
    fire_req(2'b11);
    wait_rsp(6);
    check_rsp(1'b1, 1'b0, 3);
    finish_rsp();
    fire_req(2'b01);
    wait_rsp(6);
    check_rsp(1'b0, 1'b0, 3);
    finish_rsp();

    // reset while in WAIT aborts the step
    and_mode = 1'b0;
    cfg(32'h0, 0, 1'b1, 32'hFFFF_FFFF);
    fire_req(2'b11);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wire_in", 32'(wire_in), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_wlr", 32'(wire_logic_reset), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_clear_pulse", 32'(wire_logic_reset), 32'd1);
    chk("abort_rsp_after", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_wlr_off", 32'(wire_logic_reset), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
